// File: rtl/raiz_datapath.sv
// Datapath of the restoring integer square-root unit (16-bit radicand, 8-bit root).
// Build option RAIZ_REM_OUT_EN: when defined, the remainder is captured on out_REM; otherwise out_REM is tied to 0.
module raiz_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_RAD,
    input  logic        in_RST,
    input  logic        in_S1,
    input  logic        in_S2,
    input  logic        in_S3,
    input  logic        in_S4,
    input  logic        in_DONE,
    output logic [15:0] out_Q,
    output logic        out_K,
    output logic [7:0]  out_ROOT,
    output logic [15:0] out_REM,
    output logic        out_VALID
);

    logic [15:0] r_a;
    logic [15:0] r_r;
    logic [7:0]  r_t;
    logic [15:0] r_q;
    logic        r_f;
    logic [2:0]  r_cnt;
    logic        r_done_d;
    logic [7:0]  r_root;
    logic        r_valid;

    logic [15:0] w_rn;
    logic [15:0] w_trial;
    logic        w_capture;

    // Bring down the next radicand digit pair and test against 4*T+1.
    assign w_rn      = (r_r << 2) | {14'b0, r_a[15:14]};
    assign w_trial   = w_rn - {6'b0, r_t, 2'b01};
    assign w_capture = in_DONE & ~r_done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_r   <= '0;
            r_t   <= '0;
            r_q   <= '0;
            r_f   <= 1'b0;
            r_cnt <= '0;
        end else if (in_RST) begin
            r_a   <= in_RAD;
            r_r   <= '0;
            r_t   <= '0;
            r_q   <= '0;
            r_f   <= 1'b0;
            r_cnt <= '0;
        end else if (in_S1) begin
            r_r <= w_rn;
            r_a <= r_a << 2;
            r_q <= w_trial;
            r_f <= 1'b0;
        end else if (in_S2) begin
            r_r <= r_q;
            r_f <= 1'b1;
        end else if (in_S3) begin
            r_t   <= {r_t[6:0], r_f};
            r_cnt <= r_cnt + 3'd1;
        end else if (in_S4) begin
            r_f <= 1'b0;
        end
    end

    // Result registers survive in_RST; only the async reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_d <= 1'b0;
            r_root   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_done_d <= in_DONE;
            r_valid  <= w_capture;
            if (w_capture) begin
                r_root <= r_t;
            end
        end
    end

`ifdef RAIZ_REM_OUT_EN
    logic [15:0] r_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem <= '0;
        end else if (w_capture) begin
            r_rem <= r_r;
        end
    end

    assign out_REM = r_rem;
`else
    assign out_REM = '0;
`endif

    assign out_Q     = r_q;
    assign out_K     = (r_cnt == 3'd7);
    assign out_ROOT  = r_root;
    assign out_VALID = r_valid;

endmodule

// File: tb/tb_raiz_datapath.sv
// Self-checking bench for raiz_datapath: drives the control strobes like control_raiz
// and checks against an arithmetic square-root model.
module tb_raiz_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_RAD = '0;
    logic        in_RST = 1'b0;
    logic        in_S1 = 1'b0;
    logic        in_S2 = 1'b0;
    logic        in_S3 = 1'b0;
    logic        in_S4 = 1'b0;
    logic        in_DONE = 1'b0;
    logic [15:0] out_Q;
    logic        out_K;
    logic [7:0]  out_ROOT;
    logic [15:0] out_REM;
    logic        out_VALID;

    int n_checks = 0;
    int n_fail = 0;
    int n_s2 = 0;
    int exp_root = 0;
    int exp_rem = 0;

    raiz_datapath dut (
        .clk(clk), .rst(rst), .in_RAD(in_RAD),
        .in_RST(in_RST), .in_S1(in_S1), .in_S2(in_S2), .in_S3(in_S3), .in_S4(in_S4),
        .in_DONE(in_DONE), .out_Q(out_Q), .out_K(out_K),
        .out_ROOT(out_ROOT), .out_REM(out_REM), .out_VALID(out_VALID)
    );

    always #5 clk = ~clk;

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int model_rem(input int rad);
        int r = isqrt(rad);
`ifdef RAIZ_REM_OUT_EN
        return rad - r * r;
`else
        return 0 * r;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag);
        n_checks++;
        if (out_ROOT !== 8'(exp_root)) begin
            n_fail++;
            $display("FAIL %s root: got %0d expected %0d", tag, out_ROOT, exp_root);
        end
        n_checks++;
        if (out_REM !== 16'(exp_rem)) begin
            n_fail++;
            $display("FAIL %s rem: got %0d expected %0d", tag, out_REM, exp_rem);
        end
    endtask

    // Load cycle; with overlap, lower-priority strobes ride along and must be ignored.
    task automatic load(input logic [15:0] rad, input bit overlap);
        in_RAD = rad;
        in_RST = 1'b1;
        in_S1 = overlap; in_S2 = overlap; in_S3 = overlap;
        tick;
        in_RST = 1'b0; in_S1 = 1'b0; in_S2 = 1'b0; in_S3 = 1'b0;
        n_checks++;
        if (out_Q !== 16'd0 || out_K !== 1'b0) begin
            n_fail++;
            $display("FAIL load: Q=%0h K=%0b expected Q=0 K=0", out_Q, out_K);
        end
    endtask

    // One iteration: S1, CHECK (compare Q and K), optional S2, S3, S4.
    task automatic iterate(input logic [15:0] rad, input int i, input bit overlap);
        int prefix, pt;
        logic [15:0] exp_q;
        prefix = int'(rad) >> (2 * (7 - i));
        pt = isqrt(int'(rad) >> (2 * (8 - i)));
        exp_q = 16'(prefix - (2 * pt + 1) * (2 * pt + 1));
        in_S1 = 1'b1; in_S2 = overlap; in_S3 = overlap; in_S4 = overlap;
        tick;
        in_S1 = 1'b0; in_S2 = 1'b0; in_S3 = 1'b0; in_S4 = 1'b0;
        n_checks++;
        if (out_Q !== exp_q) begin
            n_fail++;
            $display("FAIL iter%0d Q rad=%0d: got %0h expected %0h", i, rad, out_Q, exp_q);
        end
        n_checks++;
        if (out_K !== (i == 7)) begin
            n_fail++;
            $display("FAIL iter%0d K: got %0b expected %0b", i, out_K, (i == 7));
        end
        if (out_Q[15] == 1'b0) begin
            n_s2++;
            in_S2 = 1'b1; in_S3 = overlap; in_S4 = overlap;
            tick;
            in_S2 = 1'b0; in_S3 = 1'b0; in_S4 = 1'b0;
        end
        in_S3 = 1'b1; in_S4 = overlap;
        tick;
        in_S3 = 1'b0;
        in_S4 = 1'b1;
        tick;
        in_S4 = 1'b0;
    endtask

    task automatic finish_done(input logic [15:0] rad, input int hold);
        int v = 0;
        check_results("hold_before_capture");
        in_DONE = 1'b1;
        for (int c = 0; c < hold; c++) begin
            tick;
            if (out_VALID === 1'b1) v++;
        end
        in_DONE = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            if (out_VALID === 1'b1) v++;
        end
        n_checks++;
        if (v != 1) begin
            n_fail++;
            $display("FAIL valid_pulses rad=%0d hold=%0d: got %0d expected 1", rad, hold, v);
        end
        exp_root = isqrt(int'(rad));
        exp_rem = model_rem(int'(rad));
        check_results("capture");
    endtask

    task automatic run(input logic [15:0] rad, input int hold, input bit overlap);
        load(rad, overlap);
        for (int i = 0; i < 8; i++) iterate(rad, i, overlap);
        n_checks++;
        if (out_K !== 1'b0) begin
            n_fail++;
            $display("FAIL K_after_8: got %0b expected 0", out_K);
        end
        finish_done(rad, hold);
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if (out_Q !== 16'd0 || out_K !== 1'b0 || out_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: Q=%0h K=%0b VALID=%0b expected 0", out_Q, out_K, out_VALID);
        end
        check_results("reset");
        tick;
        tick;
        @(negedge clk);
        rst = 1'b1;
        tick;
    endtask

    task automatic test_known;
        run(16'd144, 1, 1'b0);
        run(16'd65535, 1, 1'b0);
        n_s2 = 0;
        run(16'd0, 1, 1'b0);
        n_checks++;
        if (n_s2 != 0) begin
            n_fail++;
            $display("FAIL zero_no_s2: got %0d S2 strobes expected 0", n_s2);
        end
        run(16'd200, 1, 1'b0);
        run(16'd1, 1, 1'b0);
    endtask

    task automatic test_done_hold;
        run(16'd50000, 5, 1'b0);
    endtask

    task automatic test_idle_hold;
        in_RAD = 16'd9999;
        in_RST = 1'b1;
        for (int c = 0; c < 4; c++) tick;
        in_RST = 1'b0;
        tick;
        check_results("idle_rst_hold");
    endtask

    task automatic test_priority;
        run(16'd40000, 2, 1'b1);
        run(16'd3, 1, 1'b1);
    endtask

    task automatic test_abort;
        int v = 0;
        load(16'd61234, 1'b0);
        for (int i = 0; i < 3; i++) iterate(16'd61234, i, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        exp_root = 0;
        exp_rem = 0;
        n_checks++;
        if (out_Q !== 16'd0 || out_K !== 1'b0 || out_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_clear: Q=%0h K=%0b VALID=%0b expected 0", out_Q, out_K, out_VALID);
        end
        check_results("abort_clear");
        tick;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (out_VALID === 1'b1) v++;
        end
        n_checks++;
        if (v != 0) begin
            n_fail++;
            $display("FAIL abort_no_valid: got %0d pulses expected 0", v);
        end
        run(16'd144, 1, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 24; n++) begin
            run(16'($urandom_range(0, 65535)), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset;
        test_known;
        test_done_hold;
        test_idle_hold;
        test_priority;
        test_abort;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
